// File: rtl/dac_ctrl_fsm.sv
// Serial refresh controller for four 8-channel 10-bit HV bias DACs.
// Snapshots the 320-bit register image, shifts 8 words per lane, then strobes LDAC.
module dac_ctrl_fsm (
  input  logic         clkin,
  input  logic         reset,
  input  logic         hv_update,
  input  logic [319:0] hv_reg_din,
  input  logic [3:0]   dac_dout,
  output logic [3:0]   dac_sclk,
  output logic [3:0]   dac_din,
  output logic [3:0]   dac_cs,
  output logic         dac_load
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HIGH  = 3'd4,
    S_LOAD     = 3'd5
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [4:0]     r_cnt, w_cnt_nxt;
  logic [2:0]     r_word, w_word_nxt;
  logic           r_pend, w_pend_nxt;
  logic           r_hv_q;
  logic [319:0]   r_shadow, w_shadow_nxt;
  logic [3:0]     r_sclk, r_din, r_cs;
  logic           r_load;
  logic [3:0]     w_sclk_nxt, w_din_nxt, w_cs_nxt;
  logic           w_load_nxt;
  logic           w_req;
  logic [4:0]     w_half;
  logic [15:0]    w_lane_word [4];
  logic           w_dout_unused;

  // 16-bit DAC word: {addr zero-extended to 4 bits, 10-bit setting, 2'b00}
  function automatic logic [15:0] dac_word(input logic [319:0] img,
                                           input logic [1:0]   dac,
                                           input logic [2:0]   addr);
    logic [8:0] base;
    base     = 9'({dac, addr}) * 9'd10;
    dac_word = {1'b0, addr, img[base +: 10], 2'b00};
  endfunction

  assign w_dout_unused = ^dac_dout;
  assign w_req         = hv_update & ~r_hv_q;

  // Next-state, counters, pending flag and shadow image
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_word_nxt   = r_word;
    w_pend_nxt   = r_pend | w_req;
    w_shadow_nxt = r_shadow;
    case (r_state)
      S_IDLE: begin
        w_pend_nxt = r_pend;
        if (w_req || r_pend) w_state_nxt = S_LATCH;
        else                 w_state_nxt = S_IDLE;
      end
      S_LATCH: begin
        w_shadow_nxt = hv_reg_din;
        w_word_nxt   = 3'd0;
        w_pend_nxt   = w_req;
        w_state_nxt  = S_CS_SETUP;
      end
      S_CS_SETUP: begin
        w_cnt_nxt   = 5'd0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == 5'd31) begin
          w_cnt_nxt   = 5'd0;
          w_state_nxt = S_CS_HIGH;
        end else begin
          w_cnt_nxt   = r_cnt + 5'd1;
        end
      end
      S_CS_HIGH: begin
        if (r_cnt == 5'd1) begin
          w_cnt_nxt = 5'd0;
          if (r_word == 3'd7) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_word_nxt  = r_word + 3'd1;
            w_state_nxt = S_CS_SETUP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_LOAD: begin
        if (r_cnt == 5'd1) begin
          w_cnt_nxt   = 5'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 5'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 5'd0;
        w_word_nxt  = 3'd0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Pin values decoded from the upcoming state so the pins stay registered without lag
  always_comb begin
    w_sclk_nxt = 4'hF;
    w_cs_nxt   = 4'hF;
    w_din_nxt  = 4'h0;
    w_load_nxt = 1'b1;
    // (c+1)/2 gives the bit already sent for even c and the next bit for odd c
    w_half     = 5'((6'(w_cnt_nxt) + 6'd1) >> 1);
    for (int k = 0; k < 4; k++) begin
      w_lane_word[k] = dac_word(w_shadow_nxt, 2'(k), w_word_nxt);
    end
    case (w_state_nxt)
      S_CS_SETUP: begin
        w_cs_nxt = 4'h0;
        for (int k = 0; k < 4; k++) begin
          w_din_nxt[k] = w_lane_word[k][15];
        end
      end
      S_SHIFT: begin
        w_cs_nxt   = 4'h0;
        w_sclk_nxt = w_cnt_nxt[0] ? 4'hF : 4'h0;
        for (int k = 0; k < 4; k++) begin
          if (w_half == 5'd16) w_din_nxt[k] = 1'b0;
          else                 w_din_nxt[k] = w_lane_word[k][4'd15 - w_half[3:0]];
        end
      end
      S_LOAD: begin
        w_load_nxt = 1'b0;
      end
      default: begin
        w_load_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_word   <= 3'd0;
      r_pend   <= 1'b0;
      r_hv_q   <= 1'b0;
      r_shadow <= 320'd0;
      r_sclk   <= 4'hF;
      r_cs     <= 4'hF;
      r_din    <= 4'h0;
      r_load   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_word   <= w_word_nxt;
      r_pend   <= w_pend_nxt;
      r_hv_q   <= hv_update;
      r_shadow <= w_shadow_nxt;
      r_sclk   <= w_sclk_nxt;
      r_cs     <= w_cs_nxt;
      r_din    <= w_din_nxt;
      r_load   <= w_load_nxt;
    end
  end

  assign dac_sclk = r_sclk;
  assign dac_cs   = r_cs;
  assign dac_din  = r_din;
  assign dac_load = r_load;

endmodule

// File: tb/tb_dac_ctrl_fsm.sv
// Self-checking bench for dac_ctrl_fsm: scoreboard of expected DAC frames
// checked by a serial-lane monitor, plus per-scenario timing checks.
module tb_dac_ctrl_fsm;

  logic         clkin;
  logic         reset;
  logic         hv_update;
  logic [319:0] hv_reg_din;
  logic [3:0]   dac_dout;
  logic [3:0]   dac_sclk;
  logic [3:0]   dac_din;
  logic [3:0]   dac_cs;
  logic         dac_load;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] cap_log [$];

  logic [15:0] sr [4];
  int   mon_bits = 0;
  int   cs_len = 0;
  int   load_len = 0;
  int   since_cs = 1000;
  int   load_pulses = 0;
  logic prev_sclk = 1'b1;
  logic prev_cs = 1'b1;
  logic prev_load = 1'b1;

  dac_ctrl_fsm dut (
    .clkin      (clkin),
    .reset      (reset),
    .hv_update  (hv_update),
    .hv_reg_din (hv_reg_din),
    .dac_dout   (dac_dout),
    .dac_sclk   (dac_sclk),
    .dac_din    (dac_din),
    .dac_cs     (dac_cs),
    .dac_load   (dac_load)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Expected word of DAC k, address w, from a register image
  function automatic logic [15:0] exp_word(input logic [319:0] d, input int k, input int w);
    logic [319:0] sh;
    logic [9:0]   v;
    sh = d >> (10 * (8 * k + w));
    v  = sh[9:0];
    return 16'((w << 12) | (int'(v) << 2));
  endfunction

  task automatic push_refresh(input logic [319:0] d);
    logic [63:0] e;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) e[16*k +: 16] = exp_word(d, k, w);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor_step();
    logic [63:0] got;
    logic [63:0] exp_v;
    if (!reset) begin
      mon_bits = 0; cs_len = 0; load_len = 0; since_cs = 1000;
      prev_sclk = 1'b1; prev_cs = 1'b1; prev_load = 1'b1;
    end else begin
      if (!dac_cs[0]) cs_len++;
      if (prev_sclk && !dac_sclk[0] && !dac_cs[0]) begin
        for (int k = 0; k < 4; k++) sr[k] = {sr[k][14:0], dac_din[k]};
        mon_bits++;
      end
      if (!prev_cs && dac_cs[0]) begin
        got = {sr[3], sr[2], sr[1], sr[0]};
        cap_log.push_back(got);
        checks++;
        if (mon_bits !== 16) begin
          errors++; $display("FAIL sclk_falls: got %0d, expected 16", mon_bits);
        end
        checks++;
        if (cs_len !== 33) begin
          errors++; $display("FAIL cs_low_len: got %0d, expected 33", cs_len);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_frame: got %h, expected no frame", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            errors++; $display("FAIL frame: got %h, expected %h", got, exp_v);
          end
        end
        since_cs = 0; mon_bits = 0; cs_len = 0;
      end else if (since_cs < 1000) begin
        since_cs++;
      end
      if (prev_load && !dac_load) begin
        checks++;
        if (since_cs !== 2) begin
          errors++; $display("FAIL load_start: got %0d cycles after cs rise, expected 2", since_cs);
        end
      end
      if (!dac_load) load_len++;
      if (!prev_load && dac_load) begin
        checks++;
        if (load_len !== 2) begin
          errors++; $display("FAIL load_len: got %0d, expected 2", load_len);
        end
        load_pulses++;
        load_len = 0;
      end
      prev_sclk = dac_sclk[0];
      prev_cs   = dac_cs[0];
      prev_load = dac_load;
    end
  endtask

  initial forever begin
    @(negedge clkin);
    monitor_step();
  end

  task automatic wait_pulses(input int target, input int budget, input string what);
    int n = 0;
    while (load_pulses < target && n < budget) begin
      @(posedge clkin); n++;
    end
    checks++;
    if (load_pulses < target) begin
      errors++; $display("FAIL %s_timeout: load pulses %0d, expected %0d", what, load_pulses, target);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string what);
    int n = 0;
    while (cap_log.size() < target && n < budget) begin
      @(posedge clkin); n++;
    end
    checks++;
    if (cap_log.size() < target) begin
      errors++; $display("FAIL %s_timeout: frames %0d, expected %0d", what, cap_log.size(), target);
    end
  endtask

  task automatic rand_image(output logic [319:0] d);
    for (int i = 0; i < 32; i++) d[10*i +: 10] = 10'($urandom_range(0, 1023));
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clkin);
    #1;
    checks++; if (dac_sclk !== 4'hF) begin errors++; $display("FAIL rst_sclk: got %h, expected f", dac_sclk); end
    checks++; if (dac_cs !== 4'hF)   begin errors++; $display("FAIL rst_cs: got %h, expected f", dac_cs); end
    checks++; if (dac_din !== 4'h0)  begin errors++; $display("FAIL rst_din: got %h, expected 0", dac_din); end
    checks++; if (dac_load !== 1'b1) begin errors++; $display("FAIL rst_load: got %b, expected 1", dac_load); end
    reset = 1'b1;
    repeat (20) @(posedge clkin);
    #1;
    checks++;
    if (dac_cs !== 4'hF || dac_load !== 1'b1 || cap_log.size() != 0) begin
      errors++; $display("FAIL idle_quiet: cs %h load %b frames %0d, expected f 1 0", dac_cs, dac_load, cap_log.size());
    end
  endtask

  task automatic test_full_refresh();
    logic [319:0] d;
    logic [63:0]  f;
    int base, base_p, first_cs, first_fall, done;
    logic seen_low;
    for (int i = 0; i < 32; i++) d[10*i +: 10] = 10'(i + 1);
    hv_reg_din = d;
    push_refresh(d);
    base = cap_log.size(); base_p = load_pulses;
    first_cs = -1; first_fall = -1; done = -1; seen_low = 1'b0;
    @(posedge clkin); #1 hv_update = 1'b1;
    @(posedge clkin);
    for (int n = 1; n <= 400 && done < 0; n++) begin
      @(posedge clkin); #1;
      if (first_cs < 0 && dac_cs == 4'h0) first_cs = n;
      if (first_fall < 0 && dac_sclk == 4'h0) first_fall = n;
      if (seen_low && dac_load) done = n;
      if (!dac_load) seen_low = 1'b1;
    end
    hv_update = 1'b0;
    checks++; if (first_cs !== 1)   begin errors++; $display("FAIL first_cs: got %0d, expected 1", first_cs); end
    checks++; if (first_fall !== 2) begin errors++; $display("FAIL first_sclk_fall: got %0d, expected 2", first_fall); end
    checks++; if (done !== 283)     begin errors++; $display("FAIL busy_len: got %0d, expected 283", done); end
    repeat (5) @(posedge clkin);
    checks++;
    if (cap_log.size() < base + 8) begin
      errors++; $display("FAIL frame_count: got %0d, expected %0d", cap_log.size() - base, 8);
    end else begin
      f = cap_log[base];
      if (f[15:0] !== 16'h0004) begin errors++; $display("FAIL dac0_f0: got %h, expected 0004", f[15:0]); end
      checks++;
      f = cap_log[base + 1];
      if (f[31:16] !== 16'h1028) begin errors++; $display("FAIL dac1_f1: got %h, expected 1028", f[31:16]); end
      checks++;
      f = cap_log[base + 7];
      if (f[63:48] !== 16'h7080) begin errors++; $display("FAIL dac3_f7: got %h, expected 7080", f[63:48]); end
    end
    checks++;
    if (load_pulses !== base_p + 1) begin
      errors++; $display("FAIL full_pulses: got %0d, expected %0d", load_pulses - base_p, 1);
    end
  endtask

  task automatic test_snapshot();
    logic [319:0] d;
    logic [63:0]  f, e;
    int base, base_p;
    rand_image(d);
    hv_reg_din = d;
    push_refresh(d);
    base = cap_log.size(); base_p = load_pulses;
    @(posedge clkin); #1 hv_update = 1'b1;
    wait_frames(base + 2, 200, "snap_mid");
    #1 hv_reg_din = {320{1'b1}};
    wait_pulses(base_p + 1, 400, "snap");
    hv_update = 1'b0;
    repeat (5) @(posedge clkin);
    for (int k = 0; k < 4; k++) e[16*k +: 16] = exp_word(d, k, 7);
    checks++;
    if (cap_log.size() < base + 8) begin
      errors++; $display("FAIL snap_frames: got %0d, expected 8", cap_log.size() - base);
    end else begin
      f = cap_log[base + 7];
      if (f !== e) begin errors++; $display("FAIL snap_last: got %h, expected %h", f, e); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL snap_left: got %0d pending frames, expected 0", exp_q.size()); end
    hv_reg_din = d;
  endtask

  task automatic test_queued();
    logic [319:0] d;
    int base, base_p;
    rand_image(d);
    hv_reg_din = d;
    push_refresh(d);
    base = cap_log.size(); base_p = load_pulses;
    @(posedge clkin); #1 hv_update = 1'b1;
    repeat (20) @(posedge clkin);
    #1 hv_update = 1'b0;
    @(posedge clkin); #1 hv_update = 1'b1;
    push_refresh(d);
    repeat (100) @(posedge clkin);
    #1 hv_update = 1'b0;
    @(posedge clkin); #1 hv_update = 1'b1;
    wait_pulses(base_p + 2, 800, "queued");
    #1 hv_update = 1'b0;
    repeat (400) @(posedge clkin);
    checks++;
    if (load_pulses !== base_p + 2) begin
      errors++; $display("FAIL queued_pulses: got %0d, expected 2", load_pulses - base_p);
    end
    checks++;
    if (cap_log.size() != base + 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL queued_frames: got %0d frames, %0d left, expected 16 and 0", cap_log.size() - base, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    logic [319:0] d;
    int base, base_p;
    rand_image(d);
    hv_reg_din = d;
    push_refresh(d);
    base = cap_log.size(); base_p = load_pulses;
    @(posedge clkin); #1 hv_update = 1'b1;
    wait_frames(base + 3, 300, "abort_mid");
    repeat (10) @(posedge clkin);
    #1 hv_update = 1'b0;
    @(posedge clkin); #1 hv_update = 1'b1;
    @(negedge clkin); #2 reset = 1'b0;
    #1;
    checks++;
    if (dac_sclk !== 4'hF || dac_cs !== 4'hF || dac_din !== 4'h0 || dac_load !== 1'b1) begin
      errors++; $display("FAIL abort_outputs: got sclk %h cs %h din %h load %b, expected f f 0 1", dac_sclk, dac_cs, dac_din, dac_load);
    end
    hv_update = 1'b0;
    repeat (3) @(posedge clkin);
    exp_q.delete();
    #1 reset = 1'b1;
    repeat (400) @(posedge clkin);
    #1;
    checks++;
    if (load_pulses !== base_p) begin
      errors++; $display("FAIL abort_load: got %0d pulses, expected 0", load_pulses - base_p);
    end
    checks++;
    if (cap_log.size() != base + 3 || dac_cs !== 4'hF) begin
      errors++; $display("FAIL abort_idle: got %0d frames cs %h, expected 3 f", cap_log.size() - base, dac_cs);
    end
  endtask

  task automatic test_level();
    int base_p;
    base_p = load_pulses;
    push_refresh(hv_reg_din);
    @(posedge clkin); #1 hv_update = 1'b1;
    repeat (5000) @(posedge clkin);
    #1 hv_update = 1'b0;
    repeat (20) @(posedge clkin);
    checks++;
    if (load_pulses !== base_p + 1) begin
      errors++; $display("FAIL level_pulses: got %0d, expected 1", load_pulses - base_p);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL level_left: got %0d pending frames, expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset      = 1'b0;
    hv_update  = 1'b0;
    hv_reg_din = 320'd0;
    dac_dout   = 4'h0;
    test_reset();
    test_full_refresh();
    test_snapshot();
    test_queued();
    test_reset_abort();
    test_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
